// File: rtl/alu_seq_core.sv
// Clocked ALU core: operands latched from the switch bus on synchronised strobes,
// ops launched by a start strobe, shifts/rotates run one bit per cycle.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic             acc_mode,
  input  logic             disp_sel,
  output logic [WIDTH-1:0] uo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic [2:0]       sync_a, sync_b, sync_s;
  logic             rise_a, rise_b, rise_s;
  logic             launch, do_load_a, do_load_b;
  logic [WIDTH-1:0] a, b, result, work;
  logic [SHW-1:0]   cnt;
  logic [2:0]       op_q;
  logic             shift_c;
  logic             flag_c, flag_v, flag_n, flag_z;

  logic [WIDTH:0]   sum_full, diff_full;
  logic [WIDTH-1:0] alu_r, shift_next;
  logic             alu_c, alu_v, shift_out;

  // Two flops absorb metastability, the third gives the previous level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_s <= '0;
    end else begin
      sync_a <= {sync_a[1:0], load_a};
      sync_b <= {sync_b[1:0], load_b};
      sync_s <= {sync_s[1:0], start};
    end
  end

  assign rise_a = sync_a[1] & ~sync_a[2];
  assign rise_b = sync_b[1] & ~sync_b[2];
  assign rise_s = sync_s[1] & ~sync_s[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A load rise in the same cycle as a start rise suppresses the launch.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    do_load_a  = 1'b0;
    do_load_b  = 1'b0;
    case (state)
      IDLE: begin
        do_load_a = rise_a;
        do_load_b = rise_b;
        if (rise_s && !rise_a && !rise_b) begin
          launch     = 1'b1;
          next_state = (op == 3'b101 || op == 3'b110 || op == 3'b111) ? SHIFT : EXEC;
        end
      end
      EXEC:    next_state = DONE;
      SHIFT:   if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  assign sum_full  = {1'b0, a} + {1'b0, b};
  assign diff_full = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      3'b000: begin
        alu_r = sum_full[WIDTH-1:0];
        alu_c = sum_full[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_full[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_r = diff_full[WIDTH-1:0];
        alu_c = ~diff_full[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_full[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  alu_r = a & b;
      3'b011:  alu_r = a | b;
      3'b100:  alu_r = a ^ b;
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    shift_next = work;
    shift_out  = 1'b0;
    case (op_q)
      3'b101: begin
        shift_next = {work[WIDTH-2:0], 1'b0};
        shift_out  = work[WIDTH-1];
      end
      3'b110: begin
        shift_next = {1'b0, work[WIDTH-1:1]};
        shift_out  = work[0];
      end
      default: begin
        shift_next = {work[WIDTH-2:0], work[WIDTH-1]};
        shift_out  = work[WIDTH-1];
      end
    endcase
  end

  // Operand, work and result registers; result/flags only change on a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      result  <= '0;
      work    <= '0;
      cnt     <= '0;
      op_q    <= '0;
      shift_c <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      if (do_load_a) a <= sw;
      if (do_load_b) b <= sw;
      if (launch) begin
        op_q    <= op;
        work    <= a;
        cnt     <= shamt;
        shift_c <= 1'b0;
      end
      case (state)
        EXEC: begin
          result <= alu_r;
          flag_c <= alu_c;
          flag_v <= alu_v;
          flag_n <= alu_r[WIDTH-1];
          flag_z <= (alu_r == '0);
        end
        SHIFT: begin
          if (cnt != '0) begin
            work    <= shift_next;
            shift_c <= shift_out;
            cnt     <= cnt - 1'b1;
          end else begin
            result <= work;
            flag_c <= shift_c;
            flag_v <= 1'b0;
            flag_n <= work[WIDTH-1];
            flag_z <= (work == '0);
          end
        end
        DONE: if (acc_mode) a <= result;
        default: ;
      endcase
    end
  end

  assign uo = disp_sel ? {{(WIDTH-4){1'b0}}, flag_c, flag_v, flag_n, flag_z} : result;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomised and directed bench for alu_seq_core (WIDTH=8, SHW=3) against an
// arithmetic reference model of operands, result and flags.
module tb_alu_seq_core;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic             load_a, load_b, start;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic             acc_mode, disp_sel;
  logic [WIDTH-1:0] uo;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_a, m_b, m_result;
  logic [3:0] m_flags;

  alu_seq_core #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .sw(sw), .load_a(load_a), .load_b(load_b),
    .start(start), .op(op), .shamt(shamt), .acc_mode(acc_mode),
    .disp_sel(disp_sel), .uo(uo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: results from plain integer arithmetic on the model operands.
  function automatic void model_op(input logic [2:0] o, input int s,
                                   output logic [7:0] r, output logic [3:0] f);
    int ai, bi, sa, sb, t;
    logic c, v;
    ai = int'(m_a);
    bi = int'(m_b);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    c = 1'b0;
    v = 1'b0;
    t = 0;
    case (o)
      3'd0: begin t = ai + bi; c = (t > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      3'd1: begin t = ai - bi; c = (ai >= bi); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      3'd2: t = ai & bi;
      3'd3: t = ai | bi;
      3'd4: t = ai ^ bi;
      3'd5: begin t = ai << s; c = (s != 0) && (((ai >> (8 - s)) & 1) == 1); end
      3'd6: begin t = ai >> s; c = (s != 0) && (((ai >> (s - 1)) & 1) == 1); end
      default: begin t = (ai << s) | (ai >> (8 - s)); c = (s != 0) && ((t & 1) == 1); end
    endcase
    r = t[7:0];
    f = {c, v, r[7], (r == 8'h00)};
  endfunction

  task automatic applyStimulus(input bit to_a, input logic [7:0] value);
    @(negedge clk);
    sw = value;
    if (to_a) load_a = 1'b1; else load_b = 1'b1;
    repeat (2) @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
    repeat (4) @(negedge clk);
    if (to_a) m_a = value; else m_b = value;
  endtask

  task automatic check_display(input string tag);
    disp_sel = 1'b0;
    #1 checkOutput({tag, " result"}, uo, m_result);
    disp_sel = 1'b1;
    #1 checkOutput({tag, " flags"}, uo, {4'h0, m_flags});
    disp_sel = 1'b0;
  endtask

  // Launch one op with start held for `hold` cycles; checks timing, single done and outputs.
  task automatic run_op(input string tag, input logic [2:0] o, input int s, input bit acc, input int hold);
    int first_done, done_cnt, busy_cnt, exp_lat, exp_busy;
    logic [7:0] r;
    logic [3:0] f;
    first_done = -1;
    done_cnt   = 0;
    busy_cnt   = 0;
    @(negedge clk);
    op = o;
    shamt = s[SHW-1:0];
    acc_mode = acc;
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (busy) busy_cnt++;
      if (k == hold) start = 1'b0;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    exp_lat  = (o >= 3'd5) ? 4 + s : 4;
    exp_busy = (o >= 3'd5) ? s + 2 : 2;
    checkOutput({tag, " commit edge"}, first_done, exp_lat);
    checkOutput({tag, " done pulses"}, done_cnt, 1);
    checkOutput({tag, " busy cycles"}, busy_cnt, exp_busy);
    model_op(o, s, r, f);
    m_result = r;
    m_flags  = f;
    if (acc) m_a = r;
    check_display(tag);
  endtask

  initial begin
    int first_done, done_cnt;
    rst = 1'b1;
    sw = '0; load_a = 0; load_b = 0; start = 0; op = '0; shamt = '0;
    acc_mode = 0; disp_sel = 0;
    m_a = 0; m_b = 0; m_result = 0; m_flags = 0;
    #1;
    checkOutput("reset uo", uo, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a long shift
    applyStimulus(1'b1, 8'h81);
    @(negedge clk);
    op = 3'd6; shamt = 3'd7; start = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrun reset busy", busy, 0);
    checkOutput("midrun reset done", done, 0);
    checkOutput("midrun reset uo", uo, 0);
    done_cnt = 0;
    start = 1'b0;
    repeat (3) begin @(negedge clk); if (done) done_cnt++; end
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (done) done_cnt++; end
    checkOutput("reset no done", done_cnt, 0);
    m_a = 0; m_b = 0; m_result = 0; m_flags = 0;
    check_display("after reset");
    run_op("add zero", 3'd0, 0, 1'b0, 2);

    // Directed cases
    applyStimulus(1'b1, 8'h7F);
    applyStimulus(1'b0, 8'h01);
    run_op("add ovf", 3'd0, 0, 1'b0, 1);
    applyStimulus(1'b1, 8'h05);
    applyStimulus(1'b0, 8'h05);
    run_op("sub eq", 3'd1, 0, 1'b0, 2);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h01);
    run_op("sub borrow", 3'd1, 0, 1'b0, 2);
    applyStimulus(1'b1, 8'h81);
    run_op("shl 1", 3'd5, 1, 1'b0, 2);
    applyStimulus(1'b1, 8'h80);
    run_op("shr 7", 3'd6, 7, 1'b0, 2);
    applyStimulus(1'b1, 8'h81);
    run_op("rol 1", 3'd7, 1, 1'b0, 2);
    run_op("rol 0", 3'd7, 0, 1'b0, 16);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b0, 8'h01);
    run_op("acc 1", 3'd0, 0, 1'b1, 2);
    run_op("acc 2", 3'd0, 0, 1'b1, 16);
    run_op("acc 3", 3'd0, 0, 1'b1, 3);

    // Start and load activity while a 7-step shift is running
    applyStimulus(1'b1, 8'h5A);
    @(negedge clk);
    op = 3'd6; shamt = 3'd7; acc_mode = 0; start = 1'b1;
    first_done = -1;
    done_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == 2) start = 1'b0;
      if (k == 5) begin start = 1'b1; sw = 8'hFF; load_a = 1'b1; end
      if (k == 7) begin start = 1'b0; load_a = 1'b0; end
    end
    checkOutput("busy start commit", first_done, 11);
    checkOutput("busy start single done", done_cnt, 1);
    model_op(3'd6, 7, m_result, m_flags);
    check_display("busy shr");
    run_op("A kept", 3'd0, 0, 1'b0, 2);

    // Load rise coincident with start rise: load taken, no launch
    @(negedge clk);
    sw = 8'h3C; op = 3'd0; start = 1'b1; load_b = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (k == 2) begin start = 1'b0; load_b = 1'b0; end
    end
    checkOutput("load beats start", done_cnt, 0);
    m_b = 8'h3C;
    run_op("B loaded", 3'd0, 0, 1'b0, 2);

    // Randomised operations
    for (int i = 0; i < 30; i++) begin
      logic [2:0] ro;
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 8'($urandom_range(0, 255)));
      ro = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d op%0d", i, ro), ro, int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), int'($urandom_range(1, 16)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
